// File: rtl/tlc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tlc : highway / country-road traffic light controller (Moore FSM + timer)
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tlc #(
  parameter int Y2RDELAY = 3,
  parameter int R2GDELAY = 2,
  parameter int CNT_W    = 8
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       X,
  output logic [1:0] hwy,
  output logic [1:0] cntry
);

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  // A zero delay would make a timed state unreachable-to-exit; clamp to 1.
  localparam int Y2R_EFF = (Y2RDELAY < 1) ? 1 : Y2RDELAY;
  localparam int R2G_EFF = (R2GDELAY < 1) ? 1 : R2GDELAY;
  localparam logic [CNT_W-1:0] Y2R_LAST = CNT_W'(Y2R_EFF - 1);
  localparam logic [CNT_W-1:0] R2G_LAST = CNT_W'(R2G_EFF - 1);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] delay_counter;
  logic             timed_state;

  always_comb begin
    next_state = S0;
    case (state)
      S0:      next_state = X ? S1 : S0;
      S1:      next_state = (delay_counter == Y2R_LAST) ? S2 : S1;
      S2:      next_state = (delay_counter == R2G_LAST) ? S3 : S2;
      S3:      next_state = X ? S3 : S4;
      S4:      next_state = (delay_counter == Y2R_LAST) ? S0 : S4;
      default: next_state = S0;
    endcase
  end

  assign timed_state = (state == S1) || (state == S2) || (state == S4);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state         <= S0;
      delay_counter <= '0;
    end else begin
      state <= next_state;
      // Restart the timer on every state change so each timed state dwells exactly its delay.
      if (next_state != state)
        delay_counter <= '0;
      else if (timed_state)
        delay_counter <= delay_counter + 1'b1;
      else
        delay_counter <= '0;
    end
  end

  always_comb begin
    hwy   = GREEN;
    cntry = RED;
    case (state)
      S1: begin hwy = YELLOW; cntry = RED;    end
      S2: begin hwy = RED;    cntry = RED;    end
      S3: begin hwy = RED;    cntry = GREEN;  end
      S4: begin hwy = RED;    cntry = YELLOW; end
      default: begin hwy = GREEN; cntry = RED; end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tlc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tlc : table-driven directed bench for tlc plus reset and safety sequences
// ---------------------------------------------------------------------------
module tb_tlc;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       X     = 1'b0;
  logic [1:0] hwy;
  logic [1:0] cntry;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       x;
    logic [2:0] st;
    logic [7:0] cnt;
    logic [1:0] hwy;
    logic [1:0] cntry;
  } vec_t;

  vec_t cyc[$];
  vec_t glitch[$];

  tlc #(.Y2RDELAY(3), .R2GDELAY(2), .CNT_W(8)) dut (
    .clock (clock),
    .clear (clear),
    .X     (X),
    .hwy   (hwy),
    .cntry (cntry)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string tag, input int idx, input vec_t v);
    check($sformatf("%s[%0d].state", tag, idx), int'(dut.state), int'(v.st));
    check($sformatf("%s[%0d].cnt", tag, idx), int'(dut.delay_counter), int'(v.cnt));
    check($sformatf("%s[%0d].hwy", tag, idx), int'(hwy), int'(v.hwy));
    check($sformatf("%s[%0d].cntry", tag, idx), int'(cntry), int'(v.cntry));
  endtask

  // Drive X at the falling edge, then look just after the next rising edge.
  task automatic apply(input string tag, input vec_t q[$]);
    foreach (q[i]) begin
      @(negedge clock);
      X = q[i].x;
      @(posedge clock);
      #1;
      check_vec(tag, i, q[i]);
    end
  endtask

  initial begin
    // Full cycle from S0: {X, state, counter after edge, hwy, cntry}
    cyc.push_back('{1'b1, 3'd1, 8'd0, Y, R});
    cyc.push_back('{1'b1, 3'd1, 8'd1, Y, R});
    cyc.push_back('{1'b1, 3'd1, 8'd2, Y, R});
    cyc.push_back('{1'b1, 3'd2, 8'd0, R, R});
    cyc.push_back('{1'b1, 3'd2, 8'd1, R, R});
    cyc.push_back('{1'b1, 3'd3, 8'd0, R, G});
    cyc.push_back('{1'b1, 3'd3, 8'd0, R, G});
    cyc.push_back('{1'b1, 3'd3, 8'd0, R, G});
    cyc.push_back('{1'b0, 3'd4, 8'd0, R, Y});
    cyc.push_back('{1'b0, 3'd4, 8'd1, R, Y});
    cyc.push_back('{1'b0, 3'd4, 8'd2, R, Y});
    cyc.push_back('{1'b0, 3'd0, 8'd0, G, R});
    cyc.push_back('{1'b0, 3'd0, 8'd0, G, R});

    // One-cycle X pulse, with X toggling inside timed states having no effect.
    glitch.push_back('{1'b1, 3'd1, 8'd0, Y, R});
    glitch.push_back('{1'b0, 3'd1, 8'd1, Y, R});
    glitch.push_back('{1'b1, 3'd1, 8'd2, Y, R});
    glitch.push_back('{1'b0, 3'd2, 8'd0, R, R});
    glitch.push_back('{1'b0, 3'd2, 8'd1, R, R});
    glitch.push_back('{1'b0, 3'd3, 8'd0, R, G});
    glitch.push_back('{1'b0, 3'd4, 8'd0, R, Y});
    glitch.push_back('{1'b1, 3'd4, 8'd1, R, Y});
    glitch.push_back('{1'b0, 3'd4, 8'd2, R, Y});
    glitch.push_back('{1'b0, 3'd0, 8'd0, G, R});

    // Reset held for two cycles
    clear = 1'b0;
    X     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.state", int'(dut.state), 0);
    check("rst.cnt", int'(dut.delay_counter), 0);
    check("rst.hwy", int'(hwy), int'(G));
    check("rst.cntry", int'(cntry), int'(R));

    @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("idle[%0d].state", i), int'(dut.state), 0);
      check($sformatf("idle[%0d].hwy", i), int'(hwy), int'(G));
    end

    apply("cyc1", cyc);
    apply("cyc2", cyc);
    apply("glitch", glitch);

    // Walk into S2, then pull clear low between edges
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      X = 1'b1;
    end
    @(posedge clock);
    #1;
    check("pre_async.state", int'(dut.state), 2);
    #2;
    clear = 1'b0;
    #1;
    check("async.state", int'(dut.state), 0);
    check("async.cnt", int'(dut.delay_counter), 0);
    check("async.hwy", int'(hwy), int'(G));
    check("async.cntry", int'(cntry), int'(R));
    @(negedge clock);
    X     = 1'b0;
    clear = 1'b1;

    // Random X: lamps must never both be non-red, and state stays legal
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      X = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      check($sformatf("safe[%0d].conflict", i), int'(hwy != R && cntry != R), 0);
      check($sformatf("safe[%0d].legal", i), int'(dut.state <= 3'd4), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
